// File: rtl/issue_rename_ctrl_pkg.sv
// Shared widths, FSM state encoding and the dispatch packet layout used by the
// issue/rename controller and its ROB allocation counter.
package issue_rename_ctrl_pkg;

    localparam int ROB_BIT  = 3;
    localparam int ROB_SIZE = 1 << ROB_BIT;
    localparam int REG_W    = 5;
    localparam int XLEN     = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [ROB_BIT-1:0] rob_entry;
        logic [XLEN-1:0]    val1;
        logic [XLEN-1:0]    val2;
        logic               has_dep1;
        logic               has_dep2;
        logic [ROB_BIT-1:0] dep1;
        logic [ROB_BIT-1:0] dep2;
    } disp_pkt_t;

endpackage

// File: rtl/issue_rename_ctrl_rob_alloc_counter.sv
// ROB tail pointer and occupancy counter: allocates the tail tag on issue,
// releases one slot per commit, and snaps back to empty on a flush.
module rob_alloc_counter
    import issue_rename_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_i,
    input  logic               free_i,
    input  logic               clear_i,
    output logic [ROB_BIT-1:0] tail_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam logic [ROB_BIT:0] FULL_COUNT = (ROB_BIT+1)'(ROB_SIZE);

    logic [ROB_BIT-1:0] tail_q, tail_d;
    logic [ROB_BIT:0]   count_q, count_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + 1'b1;
            end
            case ({alloc_i, free_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   if (count_q != '0) count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign tail_o  = tail_q;
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);

    underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(free_i && !clear_i && count_q == '0))
        else $fatal(1, "rob_commit with empty ROB");

endmodule

// File: rtl/issue_rename_ctrl.sv
// Dispatch sequencer: accepts the IQ head, reads operands, renames rd to the
// ROB tail tag, registers the dispatch packet and sequences flush recovery.
module issue_rename_ctrl
    import issue_rename_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,

    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [REG_W-1:0]   inst_rd,
    input  logic               inst_has_rd,
    input  logic [REG_W-1:0]   inst_rs1,
    input  logic [REG_W-1:0]   inst_rs2,

    input  logic               rs_full,
    input  logic               rob_commit,
    input  logic               rob_clear_up,

    output logic [REG_W-1:0]   get_id1,
    output logic [REG_W-1:0]   get_id2,
    input  logic [XLEN-1:0]    val1,
    input  logic [XLEN-1:0]    val2,
    input  logic               has_dep1,
    input  logic               has_dep2,
    input  logic [ROB_BIT-1:0] dep1,
    input  logic [ROB_BIT-1:0] dep2,

    output logic               issue_pollute,
    output logic [REG_W-1:0]   issue_reg_id,
    output logic [ROB_BIT-1:0] issue_rob_entry,

    output logic               disp_valid,
    output logic [ROB_BIT-1:0] disp_rob_entry,
    output logic [XLEN-1:0]    disp_val1,
    output logic [XLEN-1:0]    disp_val2,
    output logic               disp_has_dep1,
    output logic               disp_has_dep2,
    output logic [ROB_BIT-1:0] disp_dep1,
    output logic [ROB_BIT-1:0] disp_dep2,

    output logic               rob_full,
    output logic               rob_empty
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    ctrl_state_e        state_q;
    logic [FC_W-1:0]    flush_cnt_q;
    logic               disp_valid_q;
    disp_pkt_t          disp_q;

    logic               fire;
    logic [ROB_BIT-1:0] tail;

    // Fullness comes from the registered count, so a same-cycle commit cannot make room.
    assign inst_ready = rst_in && rdy_in && (state_q == ST_RUN) && !rob_full
                        && !rs_full && !rob_clear_up;
    assign fire       = inst_valid && inst_ready;

    assign get_id1         = inst_rs1;
    assign get_id2         = inst_rs2;
    assign issue_pollute   = fire && inst_has_rd && (inst_rd != '0);
    assign issue_reg_id    = inst_rd;
    assign issue_rob_entry = tail;

    rob_alloc_counter u_rob_alloc_counter (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .alloc_i (fire),
        .free_i  (rob_commit && rdy_in),
        .clear_i (rob_clear_up),
        .tail_o  (tail),
        .full_o  (rob_full),
        .empty_o (rob_empty)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else if (rob_clear_up) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
        end else if (rdy_in && state_q == ST_FLUSH) begin
            if (flush_cnt_q == '0) begin
                state_q <= ST_RUN;
            end else begin
                flush_cnt_q <= flush_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            disp_valid_q <= 1'b0;
            disp_q       <= '0;
        end else if (rob_clear_up) begin
            disp_valid_q <= 1'b0;
        end else if (rdy_in) begin
            disp_valid_q <= fire;
            if (fire) begin
                disp_q <= '{rob_entry: tail,     val1: val1,         val2: val2,
                            has_dep1:  has_dep1, has_dep2: has_dep2,
                            dep1:      dep1,     dep2: dep2};
            end
        end
    end

    assign disp_valid     = disp_valid_q;
    assign disp_rob_entry = disp_q.rob_entry;
    assign disp_val1      = disp_q.val1;
    assign disp_val2      = disp_q.val2;
    assign disp_has_dep1  = disp_q.has_dep1;
    assign disp_has_dep2  = disp_q.has_dep2;
    assign disp_dep1      = disp_q.dep1;
    assign disp_dep2      = disp_q.dep2;

endmodule

// File: tb/tb_issue_rename_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of ROB allocation and flush recovery.
module tb_issue_rename_ctrl;
    import issue_rename_ctrl_pkg::*;

    localparam int FLUSH_CYCLES = 2;

    logic               clk_in = 1'b0;
    logic               rst_in, rdy_in;
    logic               inst_valid, inst_ready, inst_has_rd;
    logic [4:0]         inst_rd, inst_rs1, inst_rs2;
    logic               rs_full, rob_commit, rob_clear_up;
    logic [4:0]         get_id1, get_id2;
    logic [31:0]        val1, val2;
    logic               has_dep1, has_dep2;
    logic [ROB_BIT-1:0] dep1, dep2;
    logic               issue_pollute;
    logic [4:0]         issue_reg_id;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               disp_valid;
    logic [ROB_BIT-1:0] disp_rob_entry;
    logic [31:0]        disp_val1, disp_val2;
    logic               disp_has_dep1, disp_has_dep2;
    logic [ROB_BIT-1:0] disp_dep1, disp_dep2;
    logic               rob_full, rob_empty;

    issue_rename_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_rd(inst_rd),
        .inst_has_rd(inst_has_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
        .rs_full(rs_full), .rob_commit(rob_commit), .rob_clear_up(rob_clear_up),
        .get_id1(get_id1), .get_id2(get_id2), .val1(val1), .val2(val2),
        .has_dep1(has_dep1), .has_dep2(has_dep2), .dep1(dep1), .dep2(dep2),
        .issue_pollute(issue_pollute), .issue_reg_id(issue_reg_id),
        .issue_rob_entry(issue_rob_entry), .disp_valid(disp_valid),
        .disp_rob_entry(disp_rob_entry), .disp_val1(disp_val1), .disp_val2(disp_val2),
        .disp_has_dep1(disp_has_dep1), .disp_has_dep2(disp_has_dep2),
        .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
        .rob_full(rob_full), .rob_empty(rob_empty)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: the ROB as a queue of live tags, plus flush blocking.
    int          rob_q[$];
    int          next_tag = 0;
    int          blocked  = 0;
    bit          m_dv     = 0;
    int          m_rob    = 0;
    logic [31:0] m_v1 = '0, m_v2 = '0;
    bit          m_hd1 = 0, m_hd2 = 0;
    int          m_d1 = 0, m_d2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int rd, input bit hrd, input bit commit, input bit clr);
        inst_valid   = v;
        inst_rd      = 5'(rd);
        inst_has_rd  = hrd;
        inst_rs1     = 5'($urandom);
        inst_rs2     = 5'($urandom);
        rob_commit   = commit;
        rob_clear_up = clr;
        val1         = $urandom;
        val2         = $urandom;
        has_dep1     = 1'($urandom);
        has_dep2     = 1'($urandom);
        dep1         = ROB_BIT'($urandom);
        dep2         = ROB_BIT'($urandom);
    endtask

    task automatic cycle();
        bit exp_ready, fire, exp_pol;
        #1;
        exp_ready = rst_in && rdy_in && (blocked == 0) && (rob_q.size() < ROB_SIZE)
                    && !rs_full && !rob_clear_up;
        fire      = inst_valid && exp_ready;
        exp_pol   = fire && inst_has_rd && (inst_rd != 0);
        check("inst_ready", 32'(inst_ready), 32'(exp_ready));
        check("issue_pollute", 32'(issue_pollute), 32'(exp_pol));
        check("issue_reg_id", 32'(issue_reg_id), 32'(inst_rd));
        check("issue_rob_entry", 32'(issue_rob_entry), 32'(next_tag));
        check("get_id1", 32'(get_id1), 32'(inst_rs1));
        check("get_id2", 32'(get_id2), 32'(inst_rs2));
        @(posedge clk_in);
        if (!rst_in) begin
            rob_q.delete();
            next_tag = 0; blocked = 0; m_dv = 0; m_rob = 0;
            m_v1 = '0; m_v2 = '0; m_hd1 = 0; m_hd2 = 0; m_d1 = 0; m_d2 = 0;
        end else if (rob_clear_up) begin
            rob_q.delete();
            next_tag = 0; blocked = FLUSH_CYCLES; m_dv = 0;
        end else if (rdy_in) begin
            if (blocked > 0) blocked--;
            if (rob_commit && rob_q.size() > 0) void'(rob_q.pop_front());
            m_dv = fire;
            if (fire) begin
                rob_q.push_back(next_tag);
                m_rob = next_tag; m_v1 = val1; m_v2 = val2;
                m_hd1 = has_dep1; m_hd2 = has_dep2; m_d1 = int'(dep1); m_d2 = int'(dep2);
                next_tag = (next_tag + 1) % ROB_SIZE;
            end
        end
        #1;
        check("disp_valid", 32'(disp_valid), 32'(m_dv));
        check("disp_rob_entry", 32'(disp_rob_entry), 32'(m_rob));
        check("disp_val1", disp_val1, m_v1);
        check("disp_val2", disp_val2, m_v2);
        check("disp_has_dep1", 32'(disp_has_dep1), 32'(m_hd1));
        check("disp_has_dep2", 32'(disp_has_dep2), 32'(m_hd2));
        check("disp_dep1", 32'(disp_dep1), 32'(m_d1));
        check("disp_dep2", 32'(disp_dep2), 32'(m_d2));
        check("rob_full", 32'(rob_full), 32'(rob_q.size() == ROB_SIZE));
        check("rob_empty", 32'(rob_empty), 32'(rob_q.size() == 0));
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; rs_full = 1'b0;
        drive(1, 3, 1, 0, 0);
        cycle();
        cycle();
        check("rst_empty", 32'(rob_empty), 32'd1);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_tail", 32'(issue_rob_entry), 32'd0);
        rst_in = 1'b1;

        for (int i = 0; i < 3; i++) begin
            drive(1, 5 + i, 1, 0, 0);
            #1;
            check("b2b_tag", 32'(issue_rob_entry), 32'(i));
            check("b2b_pollute", 32'(issue_pollute), 32'd1);
            cycle();
            check("b2b_disp_valid", 32'(disp_valid), 32'd1);
            check("b2b_disp_tag", 32'(disp_rob_entry), 32'(i));
        end

        for (int i = 3; i < ROB_SIZE; i++) begin
            drive(1, 8 + i, 1, 0, 0);
            cycle();
        end
        drive(1, 20, 1, 0, 0);
        #1;
        check("full_ready", 32'(inst_ready), 32'd0);
        check("full_flag", 32'(rob_full), 32'd1);
        cycle();

        drive(0, 0, 0, 1, 0);
        cycle();
        drive(1, 9, 1, 0, 0);
        #1;
        check("wrap_tag", 32'(issue_rob_entry), 32'd0);
        cycle();

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            cycle();
        end
        drive(1, 10, 1, 1, 0);
        #1;
        check("fc_ready", 32'(inst_ready), 32'd1);
        cycle();
        check("fc_tail", 32'(issue_rob_entry), 32'd2);
        check("fc_not_full", 32'(rob_full), 32'd0);
        check("fc_not_empty", 32'(rob_empty), 32'd0);

        drive(1, 0, 1, 0, 0);
        #1;
        check("x0_pollute", 32'(issue_pollute), 32'd0);
        check("x0_ready", 32'(inst_ready), 32'd1);
        cycle();
        check("x0_disp_valid", 32'(disp_valid), 32'd1);
        check("x0_disp_tag", 32'(disp_rob_entry), 32'd2);

        drive(1, 11, 1, 0, 1);
        #1;
        check("clr_ready", 32'(inst_ready), 32'd0);
        check("clr_pollute", 32'(issue_pollute), 32'd0);
        cycle();
        check("clr_empty", 32'(rob_empty), 32'd1);
        check("clr_tail", 32'(issue_rob_entry), 32'd0);
        check("clr_disp_valid", 32'(disp_valid), 32'd0);
        for (int k = 0; k < FLUSH_CYCLES; k++) begin
            drive(1, 12, 1, 0, 0);
            #1;
            check("flush_ready", 32'(inst_ready), 32'd0);
            cycle();
        end
        drive(1, 12, 1, 0, 0);
        #1;
        check("resume_ready", 32'(inst_ready), 32'd1);
        check("resume_tag", 32'(issue_rob_entry), 32'd0);
        cycle();
        check("resume_disp_tag", 32'(disp_rob_entry), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            bit rdy, clr, com;
            rdy = ($urandom_range(0, 9) < 8);
            clr = rdy && (blocked == 0) && ($urandom_range(0, 99) < 3);
            com = (rob_q.size() > 0) && ($urandom_range(0, 9) < 4);
            rst_in  = ($urandom_range(0, 199) != 0);
            rdy_in  = rdy;
            rs_full = ($urandom_range(0, 4) == 0);
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 31)),
                  1'($urandom), com, clr);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
